// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register busy scoreboard for decode/issue.
// Reads are combinational with optional same-cycle write bypass; register 0 reads as zero.
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_ready,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;

    // Lanes are applied in ascending order so the highest-index lane wins a collision.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i] && (wr_addr[i*AW +: AW] != '0)) begin
                regs_d[wr_addr[i*AW +: AW]] = wr_data[i*XLEN +: XLEN];
                busy_d[wr_addr[i*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en && (alloc_addr != '0)) begin
            busy_d[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;

        busy_cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd_val;
    logic            rd_rdy;

    // Busy is read from the current state, so an alloc is not visible until the next cycle.
    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        ra       = '0;
        rd_val   = '0;
        rd_rdy   = 1'b0;
        for (int j = 0; j < NRD; j++) begin
            ra     = rd_addr[j*AW +: AW];
            rd_val = regs_q[ra];
            rd_rdy = ~busy_q[ra];
            if (BYPASS != 0) begin
                for (int i = 0; i < NWR; i++) begin
                    if (wr_en[i] && (wr_addr[i*AW +: AW] == ra)) begin
                        rd_val = wr_data[i*XLEN +: XLEN];
                        rd_rdy = 1'b1;
                    end
                end
            end
            if (ra == '0) begin
                rd_val = '0;
                rd_rdy = 1'b1;
            end
            rd_data[j*XLEN +: XLEN] = rd_val;
            rd_ready[j]             = rd_rdy;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule
